serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: computes A - B one bit per clock, LSB first,

---
 rtl/serial_sub_pkg.sv | 25 ++
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_sub_pkg;

  // Sequencer states: waiting for work, walking the bits, presenting the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count from 0 to value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout is the borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (A - B, LSB first); optional ovf_out via SERIAL_SUB_OVF_EN.
// Latency: WIDTH+1 rising edges from the accepting start edge to done being high.
// Backpressure: start is ignored while busy; no queuing, caller must wait for IDLE.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_bit;

  // A start is only honoured when the sequencer is idle.
  assign accept   = (state == IDLE) && start;
  // The bit being processed this cycle is the operand MSB.
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  // Single shared cell; it always looks at the current LSBs and the stored borrow.
  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the status outputs derived from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand load, per-bit shift of operands/result, borrow and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a_in;
      b_sh   <= b_in;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {cell_d, res_sh[WIDTH-1:1]};
      borrow <= cell_bo;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers: updated only on the edge that enters DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else if (last_bit) begin
      diff_out   <= {cell_d, res_sh[WIDTH-1:1]};
      borrow_out <= cell_bo;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: operand signs differ and the result sign differs from A.
  // On the last bit the shift registers' LSBs are the operand sign bits and
  // the cell output is the result sign bit, so no extra sign flops are needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_out <= 1'b0;
    end else if (last_bit) begin
      ovf_out <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             ovf_out;

  int n_checks;
  int n_errors;

  // Reference-model view of what the held outputs should currently be.
  logic [WIDTH-1:0] exp_diff;
  logic             exp_borrow;
  logic             exp_ovf;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_out    (ovf_out)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_out = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: plain integer subtraction, unsigned compare, signed range.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int sa;
    int sb;
    int sd;
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    exp_diff   = WIDTH'((int'(a) - int'(b)) & ((1 << WIDTH) - 1));
    exp_borrow = (int'(a) < int'(b));
    exp_ovf    = (sd > (1 << (WIDTH - 1)) - 1) || (sd < -(1 << (WIDTH - 1)));
  endtask

  // One operation: wait for idle, pulse start, scramble inputs while busy
  // (optionally re-pulsing start at cycle glitch_at), then check latency and result.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int glitch_at);
    int k;
    int waits;
    waits = 0;
    while (busy && waits < 20) begin
      tick();
      waits++;
    end
    check({tag, "_idle"}, busy, 1'b0);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      k = i;
      if (done) break;
      if (i == 5) begin
        check({tag, "_held_diff"}, diff_out, exp_diff);
        check({tag, "_held_borrow"}, borrow_out, exp_borrow);
      end
      start = (i == glitch_at);
      a_in  = WIDTH'($urandom);
      b_in  = WIDTH'($urandom);
    end
    start = 1'b0;
    model(a, b);
    check({tag, "_latency"}, k, WIDTH + 1);
    check({tag, "_diff"}, diff_out, exp_diff);
    check({tag, "_borrow"}, borrow_out, exp_borrow);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, ovf_out, exp_ovf);
`endif
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_checks   = 0;
    n_errors   = 0;
    exp_diff   = '0;
    exp_borrow = 1'b0;
    exp_ovf    = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff_out, '0);
    check("rst_borrow", borrow_out, 1'b0);
    check("rst_ovf", ovf_out, 1'b0);

    // Directed cases.
    run_op("t1", 8'h05, 8'h03, 0);
    run_op("t2", 8'h03, 8'h05, 0);
    run_op("t3a", 8'h80, 8'h01, 0);
    run_op("t3b", 8'h7F, 8'hFF, 0);
    run_op("t4", 8'h10, 8'h01, 3);
    check("t4_value", diff_out, 8'h0F);

    // Reset in the middle of SHIFT.
    a_in  = 8'h44;
    b_in  = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_diff   = '0;
    exp_borrow = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_diff", diff_out, '0);
    check("t5_borrow", borrow_out, 1'b0);
    check("t5_ovf", ovf_out, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("t5_no_done", pulses, 0);

    // Back-to-back: second start lands in the first IDLE cycle.
    run_op("t6a", 8'hFF, 8'hFF, 0);
    run_op("t6b", 8'h00, 8'h01, 0);

    // Randomized operations, some with a stray start while busy.
    for (int n = 0; n < 30; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op("rnd", ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 7)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
